// File: rtl/uart_command_issuer.sv
// uart_command_issuer
//
// Initiator side of the UART register-access protocol. One parallel command is
// turned into the byte stream that uart_command_handler consumes:
//   UARTRST  : op
//   WRITEREG : op, addr, wdata[7:0], wdata[15:8]
//   READREG  : op, addr, then a 2-byte reply (LSB first) is popped from the RX FIFO
// Opcode 3 is reserved: accepted, nothing sent, completes with an error.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (ready only while idle)
//   cmd_opcode/addr/wdata    command fields, latched on accept
//   tx_data / tx_write       byte and push strobe toward the TX FIFO
//   tx_full                  TX FIFO full; pushes stall while high
//   rx_data / rx_read        reply byte (valid the cycle after the pop) and pop strobe
//   rx_empty                 RX FIFO empty; pops wait while high
//   rsp_valid                one-cycle completion strobe
//   rsp_data                 READREG result, held until the next successful READREG
//   rsp_error                with rsp_valid: reply timeout or reserved opcode
//   busy                     inverse of cmd_ready
module uart_command_issuer #(
    parameter int unsigned BUFFER_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter logic [BUFFER_WIDTH-1:0] UARTRST_OPCODE  = 'h00,
    parameter logic [BUFFER_WIDTH-1:0] WRITEREG_OPCODE = 'h01,
    parameter logic [BUFFER_WIDTH-1:0] READREG_OPCODE  = 'h02
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_opcode,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    output logic [BUFFER_WIDTH-1:0] tx_data,
    output logic                    tx_write,
    input  logic                    tx_full,
    input  logic [BUFFER_WIDTH-1:0] rx_data,
    output logic                    rx_read,
    input  logic                    rx_empty,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    rsp_error,
    output logic                    busy
);

    localparam logic [1:0] OpUartRst  = 2'd0;
    localparam logic [1:0] OpWriteReg = 2'd1;
    localparam logic [1:0] OpReserved = 2'd3;

    localparam int unsigned TimerWidth = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        StIdle,
        StSendOp,
        StSendAddr,
        StSendLsb,
        StSendMsb,
        StPopLsb,
        StCapLsb,
        StPopMsb,
        StCapMsb,
        StDone
    } state_e;

    state_e                  state_q;
    logic [1:0]              op_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [BUFFER_WIDTH-1:0] lsb_q;
    logic [TimerWidth-1:0]   timer_q;
    logic                    rsp_valid_q;
    logic                    rsp_error_q;
    logic [DATA_WIDTH-1:0]   rsp_data_q;

    logic                    send_state;
    logic                    pop_state;
    logic [BUFFER_WIDTH-1:0] op_byte;
    logic [BUFFER_WIDTH-1:0] send_byte;

    always_comb begin
        op_byte = READREG_OPCODE;
        if (op_q == OpUartRst) begin
            op_byte = UARTRST_OPCODE;
        end else if (op_q == OpWriteReg) begin
            op_byte = WRITEREG_OPCODE;
        end
    end

    always_comb begin
        send_byte = '0;
        case (state_q)
            StSendOp:   send_byte = op_byte;
            StSendAddr: send_byte = BUFFER_WIDTH'(addr_q);
            StSendLsb:  send_byte = wdata_q[BUFFER_WIDTH-1:0];
            StSendMsb:  send_byte = wdata_q[DATA_WIDTH-1:BUFFER_WIDTH];
            default:    send_byte = '0;
        endcase
    end

    assign send_state = state_q inside {StSendOp, StSendAddr, StSendLsb, StSendMsb};
    assign pop_state  = state_q inside {StPopLsb, StPopMsb};

    // FIFO strobes are gated combinationally by full/empty in the same cycle, so a
    // push can never land on a full FIFO and a pop never on an empty one.
    assign tx_write  = send_state & ~tx_full;
    assign tx_data   = send_byte;
    assign rx_read   = pop_state & ~rx_empty;

    assign cmd_ready = (state_q == StIdle);
    assign busy      = ~cmd_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign rsp_data  = rsp_data_q;

    // rsp_valid_q/rsp_error_q are set on the transition into StDone, so they are
    // high exactly for the single cycle spent in StDone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= 2'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            lsb_q       <= '0;
            timer_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_opcode;
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        if (cmd_opcode == OpReserved) begin
                            state_q     <= StDone;
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b1;
                        end else begin
                            state_q <= StSendOp;
                        end
                    end
                end
                StSendOp: begin
                    if (!tx_full) begin
                        if (op_q == OpUartRst) begin
                            state_q     <= StDone;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= StSendAddr;
                        end
                    end
                end
                StSendAddr: begin
                    if (!tx_full) begin
                        if (op_q == OpWriteReg) begin
                            state_q <= StSendLsb;
                        end else begin
                            state_q <= StPopLsb;
                            timer_q <= '0;
                        end
                    end
                end
                StSendLsb: begin
                    if (!tx_full) begin
                        state_q <= StSendMsb;
                    end
                end
                StSendMsb: begin
                    if (!tx_full) begin
                        state_q     <= StDone;
                        rsp_valid_q <= 1'b1;
                    end
                end
                StPopLsb, StPopMsb: begin
                    if (!rx_empty) begin
                        if (state_q == StPopLsb) begin
                            state_q <= StCapLsb;
                        end else begin
                            state_q <= StCapMsb;
                        end
                    end else if (timer_q == TimerLast) begin
                        // Reply lost: give up, rsp_data keeps its previous value.
                        state_q     <= StDone;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StCapLsb: begin
                    lsb_q   <= rx_data;
                    state_q <= StPopMsb;
                    timer_q <= '0;
                end
                StCapMsb: begin
                    rsp_data_q  <= {rx_data, lsb_q};
                    state_q     <= StDone;
                    rsp_valid_q <= 1'b1;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_command_issuer.sv
module tb_uart_command_issuer;

    localparam int unsigned Timeout = 16;
    localparam logic [7:0] RstByte = 8'h00;
    localparam logic [7:0] WrByte  = 8'h01;
    localparam logic [7:0] RdByte  = 8'h02;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_opcode = 2'd0;
    logic [7:0]  cmd_addr = 8'h00;
    logic [15:0] cmd_wdata = 16'h0000;
    logic [7:0]  tx_data;
    logic        tx_write;
    logic        tx_full = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_read;
    logic        rx_empty = 1'b1;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_error;
    logic        busy;

    uart_command_issuer #(
        .BUFFER_WIDTH   (8),
        .ADDR_WIDTH     (8),
        .DATA_WIDTH     (16),
        .TIMEOUT_CYCLES (Timeout),
        .UARTRST_OPCODE (RstByte),
        .WRITEREG_OPCODE(WrByte),
        .READREG_OPCODE (RdByte)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_opcode(cmd_opcode),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .tx_data   (tx_data),
        .tx_write  (tx_write),
        .tx_full   (tx_full),
        .rx_data   (rx_data),
        .rx_read   (rx_read),
        .rx_empty  (rx_empty),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_error (rsp_error),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic        upd;
        logic [15:0] data;
    } rsp_t;

    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    rsp_t        rspq[$];
    logic [15:0] model_data = 16'h0000;
    bit          rx_stuck = 1'b0;
    int          n_push = 0;
    int          stall_at = 0;
    int          stall_len = 0;
    int          stall_rem = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: byte stream and response implied by one command.
    task automatic expect_cmd(input logic [1:0] op, input logic [7:0] addr,
                              input logic [15:0] wd, input bit rd_ok, input logic [15:0] rd_word);
        rsp_t r;
        case (op)
            2'd0: txq.push_back(RstByte);
            2'd1: begin
                txq.push_back(WrByte);
                txq.push_back(addr);
                txq.push_back(wd[7:0]);
                txq.push_back(wd[15:8]);
            end
            2'd2: begin
                txq.push_back(RdByte);
                txq.push_back(addr);
            end
            default: ;
        endcase
        r.err  = (op == 2'd3) || (op == 2'd2 && !rd_ok);
        r.upd  = (op == 2'd2 && rd_ok);
        r.data = rd_word;
        rspq.push_back(r);
    endtask

    task automatic load_reply(input logic [7:0] lsb, input logic [7:0] msb, output logic [15:0] w);
        rxq.push_back(lsb);
        rxq.push_back(msb);
        w = 16'(int'(msb) * 256 + int'(lsb));
        rx_empty = rx_stuck || (rxq.size() == 0);
    endtask

    // One clock: strobes are noted mid-cycle, FIFO/stall models update just after the edge.
    task automatic tick();
        bit pop_pend;
        bit push_pend;
        @(negedge clk);
        pop_pend  = rx_read;
        push_pend = tx_write;
        @(posedge clk);
        #1;
        if (pop_pend && rxq.size() > 0) rx_data = rxq.pop_front();
        else rx_data = 8'hEE;
        if (push_pend) begin
            n_push++;
            if (n_push == stall_at) stall_rem = stall_len;
        end
        tx_full = (stall_rem > 0);
        if (stall_rem > 0) stall_rem--;
        rx_empty = rx_stuck || (rxq.size() == 0);
    endtask

    task automatic accept(input logic [1:0] op, input logic [7:0] addr, input logic [15:0] wd);
        int n;
        n = 0;
        cmd_opcode = op;
        cmd_addr   = addr;
        cmd_wdata  = wd;
        cmd_valid  = 1'b1;
        while (!cmd_ready && n < 300) begin
            tick();
            n++;
        end
        check("accept_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid  = 1'b0;
        cmd_opcode = 2'($urandom);
        cmd_addr   = 8'($urandom);
        cmd_wdata  = 16'($urandom);
        n_push     = 0;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [15:0] wd,
                           input bit rd_ok, input logic [15:0] rd_word, input int exp_lat,
                           input string name);
        int n;
        expect_cmd(op, addr, wd, rd_ok, rd_word);
        accept(op, addr, wd);
        n = 1;
        while (!rsp_valid && n < 300) begin
            tick();
            n++;
        end
        check({name, "_latency"}, 32'(n), 32'(exp_lat));
        tick();
        check({name, "_ready_after"}, 32'(cmd_ready), 32'd1);
        check({name, "_bytes_left"}, 32'(txq.size()), 32'd0);
        check({name, "_rsp_left"}, 32'(rspq.size()), 32'd0);
        txq.delete();
        rspq.delete();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_tx_write"}, 32'(tx_write), 32'd0);
        check({tag, "_rx_read"}, 32'(rx_read), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_error"}, 32'(rsp_error), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin : cmp
        rsp_t r;
        if (!rst) begin
            check("busy_vs_ready", 32'(busy), 32'(!cmd_ready));
            if (tx_write) begin
                check("push_while_full", 32'(tx_full), 32'd0);
                check("push_and_pop", 32'(rx_read), 32'd0);
                if (txq.size() == 0) begin
                    check("unexpected_push", 32'(tx_data), 32'hFFFF_FFFF);
                end else begin
                    check("tx_byte", 32'(tx_data), 32'(txq.pop_front()));
                end
            end
            if (rx_read) check("pop_while_empty", 32'(rx_empty), 32'd0);
            if (rsp_valid) begin
                if (rspq.size() == 0) begin
                    check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    r = rspq.pop_front();
                    check("rsp_error", 32'(rsp_error), 32'(r.err));
                    if (r.upd) model_data = r.data;
                end
            end
            check("rsp_data", 32'(rsp_data), 32'(model_data));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        logic [15:0] w;
        int          n;

        #12;
        check_reset("por");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        run_cmd(2'd0, 8'h00, 16'h0000, 1'b0, 16'h0000, 2, "uartrst");
        run_cmd(2'd1, 8'h1F, 16'h0F03, 1'b0, 16'h0000, 5, "writereg");

        stall_at  = 2;
        stall_len = 10;
        run_cmd(2'd1, 8'h1F, 16'h0F03, 1'b0, 16'h0000, 15, "writereg_stall");
        stall_at  = 0;

        load_reply(8'h03, 8'h0F, w);
        run_cmd(2'd2, 8'h1F, 16'h0000, 1'b1, w, 7, "readreg");
        check("readreg_word", 32'(rsp_data), 32'h0F03);

        rx_stuck = 1'b1;
        rx_empty = 1'b1;
        run_cmd(2'd2, 8'h20, 16'h0000, 1'b0, 16'h0000, 19, "timeout_lsb");
        rx_stuck = 1'b0;
        check("timeout_lsb_keeps", 32'(rsp_data), 32'h0F03);

        rxq.push_back(8'h55);
        rx_empty = 1'b0;
        run_cmd(2'd2, 8'h21, 16'h0000, 1'b0, 16'h0000, 21, "timeout_msb");
        check("timeout_msb_keeps", 32'(rsp_data), 32'h0F03);

        run_cmd(2'd3, 8'h7E, 16'h1234, 1'b0, 16'h0000, 1, "reserved");
        check("reserved_keeps", 32'(rsp_data), 32'h0F03);

        // Reset while a WRITEREG is stuck in its third byte.
        stall_at  = 2;
        stall_len = 1000;
        expect_cmd(2'd1, 8'h1F, 16'h0F03, 1'b0, 16'h0000);
        accept(2'd1, 8'h1F, 16'h0F03);
        n = 0;
        while (n_push < 2 && n < 50) begin
            tick();
            n++;
        end
        check("midcmd_two_pushes", 32'(n_push), 32'd2);
        check("midcmd_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_reset("midcmd");
        txq.delete();
        rspq.delete();
        model_data = 16'h0000;
        stall_at   = 0;
        stall_rem  = 0;
        tx_full    = 1'b0;
        tick();
        tick();
        rst    = 1'b0;
        n_push = 0;
        repeat (6) tick();
        check("no_push_after_reset", 32'(n_push), 32'd0);

        run_cmd(2'd0, 8'h00, 16'h0000, 1'b0, 16'h0000, 2, "post_uartrst");
        run_cmd(2'd1, 8'hA5, 16'hC33C, 1'b0, 16'h0000, 5, "post_writereg");
        load_reply(8'hEF, 8'hBE, w);
        run_cmd(2'd2, 8'h5A, 16'h0000, 1'b1, w, 7, "post_readreg");
        check("post_readreg_word", 32'(rsp_data), 32'hBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
